snn_frame_ctrl: RTL

SNN_FRAME_CTRL -- requirements
Module: snn_frame_ctrl

---
 rtl/snn_pkg.sv | 20 ++
 rtl/snn_byte_unpack.sv | 26 ++
 rtl/snn_frame_ctrl.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/snn_pkg.sv
// Shared types and constants for the SNN frame controller.
package snn_pkg;

  localparam int NUM_BITS_DEF = 784;

  typedef enum logic [2:0] {
    ST_WAIT_BYTE = 3'd0,
    ST_UNPACK    = 3'd1,
    ST_START     = 3'd2,
    ST_WAIT_CORE = 3'd3,
    ST_SEND      = 3'd4,
    ST_WAIT_TX   = 3'd5
  } state_e;

  // Classified digit to its ASCII character.
  function automatic logic [7:0] ascii_digit(input logic [3:0] digit);
    return 8'h30 + {4'h0, digit};
  endfunction

endpackage

// File: rtl/snn_byte_unpack.sv
// Byte-wide shift register that serialises a received byte LSB first.
module snn_byte_unpack (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_load,
  input  logic [7:0] i_data,
  input  logic       i_shift,
  output logic       o_bit
);

  logic [7:0] r_shift;

  // Load on byte acceptance, shift right once per unpacked bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift <= 8'h00;
    end else if (i_load) begin
      r_shift <= i_data;
    end else if (i_shift) begin
      r_shift <= {1'b0, r_shift[7:1]};
    end
  end

  assign o_bit = r_shift[0];

endmodule

// File: rtl/snn_frame_ctrl.sv
// Frame controller: unpacks UART bytes into the pixel RAM, runs the SNN core
// and sends the classified digit back as ASCII.
module snn_frame_ctrl
  import snn_pkg::*;
#(
  parameter int NUM_BITS = NUM_BITS_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_rdy,
  input  logic [7:0] rx_data,
  output logic       clr_rx_rdy,
  output logic       ram_we,
  output logic [9:0] ram_addr,
  output logic       ram_data,
  input  logic [9:0] core_addr,
  output logic       core_start,
  input  logic       core_done,
  input  logic [3:0] core_digit,
  output logic       tx_start,
  output logic [7:0] tx_data,
  input  logic       tx_done,
  output logic       busy
);

  localparam logic [9:0] LAST_ADDR = 10'(NUM_BITS - 1);

  state_e     r_state;
  state_e     w_next;
  logic [9:0] r_wptr;
  logic [2:0] r_bcnt;
  logic [7:0] r_tx_data;
  logic       w_clr;
  logic       w_we;
  logic       w_start;
  logic       w_tx_start;
  logic       w_bit;
  logic       w_core_owns_ram;

  snn_byte_unpack u_unpack (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_clr),
    .i_data  (rx_data),
    .i_shift (w_we),
    .o_bit   (w_bit)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_WAIT_BYTE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode and per-state strobes.
  always_comb begin
    w_next     = r_state;
    w_clr      = 1'b0;
    w_we       = 1'b0;
    w_start    = 1'b0;
    w_tx_start = 1'b0;
    case (r_state)
      ST_WAIT_BYTE: begin
        if (rx_rdy) begin
          w_clr  = 1'b1;
          w_next = ST_UNPACK;
        end else begin
          w_next = ST_WAIT_BYTE;
        end
      end
      ST_UNPACK: begin
        w_we = 1'b1;
        if (r_bcnt == 3'd7) begin
          if (r_wptr == LAST_ADDR) begin
            w_next = ST_START;
          end else begin
            w_next = ST_WAIT_BYTE;
          end
        end else begin
          w_next = ST_UNPACK;
        end
      end
      ST_START: begin
        w_start = 1'b1;
        w_next  = ST_WAIT_CORE;
      end
      ST_WAIT_CORE: begin
        if (core_done) begin
          w_next = ST_SEND;
        end else begin
          w_next = ST_WAIT_CORE;
        end
      end
      ST_SEND: begin
        w_tx_start = 1'b1;
        w_next     = ST_WAIT_TX;
      end
      ST_WAIT_TX: begin
        if (tx_done) begin
          w_next = ST_WAIT_BYTE;
        end else begin
          w_next = ST_WAIT_TX;
        end
      end
      default: begin
        w_next = ST_WAIT_BYTE;
      end
    endcase
  end

  // Write pointer wraps at the last pixel so it never leaves the frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr    <= 10'd0;
      r_bcnt    <= 3'd0;
      r_tx_data <= 8'h00;
    end else begin
      if (w_clr) begin
        r_bcnt <= 3'd0;
      end else if (w_we) begin
        r_bcnt <= r_bcnt + 3'd1;
      end
      if (w_we) begin
        r_wptr <= (r_wptr == LAST_ADDR) ? 10'd0 : r_wptr + 10'd1;
      end
      if ((r_state == ST_WAIT_CORE) && core_done) begin
        r_tx_data <= ascii_digit(core_digit);
      end
    end
  end

  assign w_core_owns_ram = (r_state == ST_START) || (r_state == ST_WAIT_CORE);

  assign clr_rx_rdy = w_clr;
  assign ram_we     = w_we;
  assign ram_data   = w_we & w_bit;
  assign ram_addr   = w_core_owns_ram ? core_addr : r_wptr;
  assign core_start = w_start;
  assign tx_start   = w_tx_start;
  assign tx_data    = r_tx_data;
  assign busy       = (r_state != ST_WAIT_BYTE);

endmodule
